// File: rtl/data_memory.sv
// Byte-addressable 32-bit data memory with RV32-style load/store sizing and a post-reset clear sequence.
// Latency: loads are combinational (zero cycles); stores commit on the next rising clock edge.
// Backpressure: busy is high for DEPTH_WORDS cycles after reset; stores are dropped and loads return 0 meanwhile.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   dmem_rw_addr              byte address; upper bits beyond the array size are ignored (wrap)
//   dmem_w_data, dmem_w_en    right-aligned store data and store strobe
//   funct3                    000 B, 001 H, 010 W, 100 BU, 101 HU
//   dmem_r_data               extended load result
//   busy                      clear sequence in progress
//   misalign_err/addr, err_count   misalignment trap status (trap build only, else tied to 0)
//
// Build option: define DMEM_MISALIGN_TRAP_EN to suppress misaligned accesses and record them;
// otherwise misaligned accesses execute at the aligned-down address.
module data_memory #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dmem_rw_addr,
   input  logic [31:0] dmem_w_data,
   input  logic        dmem_w_en,
   input  logic [2:0]  funct3,
   output logic [31:0] dmem_r_data,
   output logic        busy,
   output logic        misalign_err,
   output logic [31:0] misalign_addr,
   output logic [7:0]  err_count
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic {CLEAR, READY} state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  clr_idx_q, clr_idx_d;

   logic [31:0]    mem [0:DEPTH_WORDS-1];

   logic [AW-1:0]  word_idx;
   logic [1:0]     lane;
   logic [31:0]    rd_word;
   logic [7:0]     rd_byte;
   logic [15:0]    rd_half;
   logic           misaligned;
   logic           trap;

   logic           wr_en;
   logic [AW-1:0]  wr_idx;
   logic [3:0]     wr_be;
   logic [31:0]    wr_dat;

   assign word_idx = dmem_rw_addr[AW+1:2];
   assign lane     = dmem_rw_addr[1:0];
   assign rd_word  = mem[word_idx];

   // ---------------- clear sequencer ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      busy      = 1'b0;
      case (state_q)
         CLEAR: begin
            busy      = 1'b1;
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == {AW{1'b1}}) state_d = READY;
         end
         READY:   busy = 1'b0;
         default: state_d = CLEAR;
      endcase
   end

   // ---------------- misalignment detect ----------------
   always_comb begin
      misaligned = 1'b0;
      if ((funct3 == 3'b001 || funct3 == 3'b101) && lane[0]) misaligned = 1'b1;
      if (funct3 == 3'b010 && lane != 2'b00)                 misaligned = 1'b1;
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign trap = misaligned;

   // Every non-busy cycle is an access (load when dmem_w_en=0, store otherwise).
   always_ff @(posedge clock) begin
      if (reset) begin
         misalign_err  <= 1'b0;
         misalign_addr <= '0;
         err_count     <= '0;
      end else if (!busy && misaligned) begin
         misalign_err <= 1'b1;
         if (!misalign_err) misalign_addr <= dmem_rw_addr;
         if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end
`else
   logic unused_bits;

   assign trap          = 1'b0;
   assign misalign_err  = 1'b0;
   assign misalign_addr = '0;
   assign err_count     = '0;
   assign unused_bits   = ^{dmem_rw_addr[31:AW+2], misaligned};
`endif

   // ---------------- load path ----------------
   // Half lane uses addr[1] only and word ignores addr[1:0], which gives the
   // aligned-down behaviour for free when trapping is off.
   always_comb begin
      case (lane)
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

      dmem_r_data = '0;
      case (funct3)
         3'b000:  dmem_r_data = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  dmem_r_data = {{16{rd_half[15]}}, rd_half};
         3'b010:  dmem_r_data = rd_word;
         3'b100:  dmem_r_data = {24'd0, rd_byte};
         3'b101:  dmem_r_data = {16'd0, rd_half};
         default: dmem_r_data = '0;
      endcase
      if (busy || trap) dmem_r_data = '0;
   end

   // ---------------- write port (clear has priority over user stores) ----------------
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = word_idx;
      wr_be  = 4'b0000;
      wr_dat = '0;
      if (busy) begin
         wr_en  = !reset;
         wr_idx = clr_idx_q;
         wr_be  = 4'b1111;
      end else if (dmem_w_en && !trap) begin
         case (funct3)
            3'b000: begin
               wr_en  = 1'b1;
               wr_be  = 4'b0001 << lane;
               wr_dat = {4{dmem_w_data[7:0]}};
            end
            3'b001: begin
               wr_en  = 1'b1;
               wr_be  = lane[1] ? 4'b1100 : 4'b0011;
               wr_dat = {2{dmem_w_data[15:0]}};
            end
            3'b010: begin
               wr_en  = 1'b1;
               wr_be  = 4'b1111;
               wr_dat = dmem_w_data;
            end
            default: wr_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (DEPTH_WORDS=1024): clear timing, load/store sizing,
// same-cycle read-old-data, wrap-around, invalid funct3, mid-clear reset, misalignment handling.
module tb_data_memory;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dmem_rw_addr = '0;
   logic [31:0] dmem_w_data = '0;
   logic        dmem_w_en = 1'b0;
   logic [2:0]  funct3 = 3'b010;
   logic [31:0] dmem_r_data;
   logic        busy;
   logic        misalign_err;
   logic [31:0] misalign_addr;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        w_en;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [2:0]  f3;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[$];

   data_memory #(.DEPTH_WORDS(1024)) dut (
      .clock         (clock),
      .reset         (reset),
      .dmem_rw_addr  (dmem_rw_addr),
      .dmem_w_data   (dmem_w_data),
      .dmem_w_en     (dmem_w_en),
      .funct3        (funct3),
      .dmem_r_data   (dmem_r_data),
      .busy          (busy),
      .misalign_err  (misalign_err),
      .misalign_addr (misalign_addr),
      .err_count     (err_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      dmem_w_en    = w;
      dmem_rw_addr = a;
      dmem_w_data  = d;
      funct3       = f;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 3'b010);
   endtask

   task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic [31:0] e, input string n);
      vec_t v;
      v.w_en = w; v.addr = a; v.wdat = d; v.f3 = f; v.exp = e; v.name = n;
      tbl.push_back(v);
   endtask

   // Counts the cycles busy stays high; a stuck busy ends at the bound and fails the count check.
   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 3000) begin
         cnt++;
         tick();
      end
   endtask

   initial begin
      int cnt;

      // ---------------- reset and first clear ----------------
      idle();
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_rdata", dmem_r_data, 32'h0);
      chk("rst_err", {31'd0, misalign_err}, 32'd0);
      chk("rst_addr", misalign_addr, 32'h0);
      chk("rst_cnt", {24'd0, err_count}, 32'd0);
      reset = 1'b0;

      // A store to an already-cleared word mid-clear must be dropped, and reads stay 0.
      cnt = 0;
      while (busy === 1'b1 && cnt < 3000) begin
         if (cnt == 10) begin
            drive(1'b1, 32'h0, 32'h12345678, 3'b010);
            #1 chk("busy_rdata_zero", dmem_r_data, 32'h0);
         end else begin
            idle();
         end
         cnt++;
         tick();
      end
      idle();
      chk("busy_cycles", cnt, 32'd1024);
      drive(1'b0, 32'h0FFC, 32'h0, 3'b010);
      #1 chk("lw_0ffc_cleared", dmem_r_data, 32'h0);
      drive(1'b0, 32'h0, 32'h0, 3'b010);
      #1 chk("busy_store_dropped", dmem_r_data, 32'h0);
      tick();

      // ---------------- misalignment ----------------
      drive(1'b1, 32'h42, 32'hCAFEF00D, 3'b010);
      tick();
      drive(1'b0, 32'h55, 32'h0, 3'b001);
      #1 chk("lh_55", dmem_r_data, 32'h0);
      tick();
`ifdef DMEM_MISALIGN_TRAP_EN
      drive(1'b0, 32'h40, 32'h0, 3'b010);
      #1 chk("word40_unchanged", dmem_r_data, 32'h0);
      chk("mis_err", {31'd0, misalign_err}, 32'd1);
      chk("mis_addr", misalign_addr, 32'h42);
      chk("mis_cnt", {24'd0, err_count}, 32'd2);
      tick();
      drive(1'b0, 32'h46, 32'h0, 3'b010);
      #1 chk("lw_46_zero", dmem_r_data, 32'h0);
      tick();
      chk("mis_cnt3", {24'd0, err_count}, 32'd3);
      chk("mis_addr_sticky", misalign_addr, 32'h42);
`else
      drive(1'b0, 32'h40, 32'h0, 3'b010);
      #1 chk("word40_written", dmem_r_data, 32'hCAFEF00D);
      drive(1'b0, 32'h43, 32'h0, 3'b001);
      #1 chk("lh_43_down", dmem_r_data, 32'hFFFFCAFE);
      drive(1'b0, 32'h41, 32'h0, 3'b010);
      #1 chk("lw_41_down", dmem_r_data, 32'hCAFEF00D);
      drive(1'b0, 32'h41, 32'h0, 3'b101);
      #1 chk("lhu_41_down", dmem_r_data, 32'h0000F00D);
      chk("mis_err_off", {31'd0, misalign_err}, 32'd0);
      chk("mis_addr_off", misalign_addr, 32'h0);
      chk("mis_cnt_off", {24'd0, err_count}, 32'd0);
      tick();
`endif
      idle();

      // ---------------- vector table ----------------
      // Each row is presented for one cycle; exp is the combinational read in that same cycle.
      add(1'b1, 32'h10,       32'h8081F00F, 3'b010, 32'h00000000, "sw_10_old");
      add(1'b0, 32'h10,       32'h0,        3'b000, 32'h0000000F, "lb_10");
      add(1'b0, 32'h13,       32'h0,        3'b100, 32'h00000080, "lbu_13");
      add(1'b0, 32'h12,       32'h0,        3'b001, 32'hFFFF8081, "lh_12");
      add(1'b0, 32'h10,       32'h0,        3'b101, 32'h0000F00F, "lhu_10");
      add(1'b0, 32'h10,       32'h0,        3'b010, 32'h8081F00F, "lw_10");
      add(1'b0, 32'h13,       32'h0,        3'b000, 32'hFFFFFF80, "lb_13");
      add(1'b0, 32'h10,       32'h0,        3'b001, 32'hFFFFF00F, "lh_10");
      add(1'b1, 32'h20,       32'h11223344, 3'b010, 32'h00000000, "sw_20_old");
      add(1'b1, 32'h21,       32'h123456AA, 3'b000, 32'h00000033, "sb_21_old");
      add(1'b0, 32'h20,       32'h0,        3'b010, 32'h1122AA44, "lw_20_after_sb");
      add(1'b1, 32'h22,       32'hFFFFBBCC, 3'b001, 32'h00001122, "sh_22_old");
      add(1'b0, 32'h20,       32'h0,        3'b010, 32'hBBCCAA44, "lw_20_after_sh");
      add(1'b1, 32'h20,       32'h55667788, 3'b010, 32'hBBCCAA44, "sw_20_reads_old");
      add(1'b0, 32'h20,       32'h0,        3'b010, 32'h55667788, "lw_20_new");
      add(1'b1, 32'h1000,     32'hDEADBEEF, 3'b010, 32'h00000000, "sw_1000_old");
      add(1'b0, 32'h0,        32'h0,        3'b010, 32'hDEADBEEF, "lw_0_wrap");
      add(1'b0, 32'h1000,     32'h0,        3'b010, 32'hDEADBEEF, "lw_1000");
      add(1'b0, 32'h0,        32'h0,        3'b011, 32'h00000000, "ld_f3_011");
      add(1'b0, 32'h0,        32'h0,        3'b110, 32'h00000000, "ld_f3_110");
      add(1'b0, 32'h0,        32'h0,        3'b111, 32'h00000000, "ld_f3_111");
      add(1'b1, 32'h0,        32'h12345678, 3'b011, 32'h00000000, "st_f3_011");
      add(1'b0, 32'h0,        32'h0,        3'b010, 32'hDEADBEEF, "lw_0_after_011");
      add(1'b1, 32'h0,        32'h00000000, 3'b100, 32'h000000EF, "st_f3_100");
      add(1'b0, 32'h0,        32'h0,        3'b010, 32'hDEADBEEF, "lw_0_after_100");
      add(1'b0, 32'h1002,     32'h0,        3'b101, 32'h0000DEAD, "lhu_1002");
      add(1'b0, 32'hFFFF0003, 32'h0,        3'b000, 32'hFFFFFFDE, "lb_hi_addr");

      foreach (tbl[i]) begin
         drive(tbl[i].w_en, tbl[i].addr, tbl[i].wdat, tbl[i].f3);
         #1 chk(tbl[i].name, dmem_r_data, tbl[i].exp);
         tick();
      end
      idle();

      // ---------------- reset mid-clear with a store presented ----------------
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 500) begin
         cnt++;
         tick();
      end
      chk("midclear_reached", cnt, 32'd500);
      reset = 1'b1;
      drive(1'b1, 32'h0FF8, 32'hA5A5A5A5, 3'b010);
      tick();
      reset = 1'b0;
      idle();
      chk("midclear_busy", {31'd0, busy}, 32'd1);
      count_busy(cnt);
      chk("restart_busy_cycles", cnt, 32'd1024);
      drive(1'b0, 32'h0FF8, 32'h0, 3'b010);
      #1 chk("midclear_store_dropped", dmem_r_data, 32'h0);
      drive(1'b0, 32'h0, 32'h0, 3'b010);
      #1 chk("reclear_word0", dmem_r_data, 32'h0);
      tick();

      // ---------------- error counter saturation ----------------
      for (int k = 0; k < 260; k++) begin
         drive(1'b0, 32'h1, 32'h0, 3'b010);
         tick();
      end
      idle();
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("cnt_saturate", {24'd0, err_count}, 32'd255);
      chk("sat_addr", misalign_addr, 32'h1);
`else
      chk("cnt_const0", {24'd0, err_count}, 32'd0);
      chk("err_const0", {31'd0, misalign_err}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
